// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - IF-stage BHT/BTB branch predictor with ID-stage resolve and redirect
// Direct-mapped table of 2-bit saturating counters plus targets; lookup never bypasses a same-cycle update.
module branch_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_res_valid,
  input  logic [31:0] i_res_pc,
  input  logic        i_res_taken,
  input  logic [31:0] i_res_target,
  input  logic        i_res_pred_taken,
  input  logic [31:0] i_res_pred_target,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_branch_count,
  output logic [31:0] o_mispredict_count
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  logic [31:0]         r_branch_count;
  logic [31:0]         r_mispredict_count;

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0]   w_if_tag;
  logic [INDEX_BITS-1:0] w_res_idx;
  logic [TAG_BITS-1:0]   w_res_tag;
  logic                  w_if_hit;
  logic                  w_res_hit;
  logic                  w_pred_taken;
  logic                  w_mispredict;
  logic [1:0]            w_ctr_inc;
  logic [1:0]            w_ctr_dec;
  logic                  w_unused;

  assign w_if_idx  = i_if_pc[INDEX_BITS+1:2];
  assign w_if_tag  = i_if_pc[31:INDEX_BITS+2];
  assign w_res_idx = i_res_pc[INDEX_BITS+1:2];
  assign w_res_tag = i_res_pc[31:INDEX_BITS+2];
  assign w_unused  = ^{i_if_pc[1:0], i_res_pc[1:0]};

  assign w_if_hit  = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_res_hit = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);

  // Table state during the reset cycle is stale, so the prediction is masked explicitly.
  assign w_pred_taken  = !i_rst && w_if_hit && r_ctr[w_if_idx][1];
  assign o_pred_taken  = w_pred_taken;
  assign o_pred_target = w_pred_taken ? r_target[w_if_idx] : (i_if_pc + 32'd4);

  assign w_mispredict  = i_res_valid &&
                         ((i_res_taken != i_res_pred_taken) ||
                          (i_res_taken && (i_res_target != i_res_pred_target)));
  assign o_mispredict  = w_mispredict;
  assign o_redirect_pc = i_res_taken ? i_res_target : (i_res_pc + 32'd4);

  assign w_ctr_inc = (r_ctr[w_res_idx] == 2'b11) ? 2'b11 : (r_ctr[w_res_idx] + 2'd1);
  assign w_ctr_dec = (r_ctr[w_res_idx] == 2'b00) ? 2'b00 : (r_ctr[w_res_idx] - 2'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_ctr[i]    <= 2'b01;
        r_target[i] <= 32'd0;
      end
      r_branch_count     <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else if (i_res_valid) begin
      r_branch_count <= r_branch_count + 32'd1;
      if (w_mispredict) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
      if (w_res_hit) begin
        if (i_res_taken) begin
          r_ctr[w_res_idx]    <= w_ctr_inc;
          r_target[w_res_idx] <= i_res_target;
        end else begin
          r_ctr[w_res_idx] <= w_ctr_dec;
        end
      end else if (i_res_taken) begin
        // Taken miss evicts whatever aliased entry occupies this index.
        r_valid[w_res_idx]  <= 1'b1;
        r_tag[w_res_idx]    <= w_res_tag;
        r_ctr[w_res_idx]    <= 2'b10;
        r_target[w_res_idx] <= i_res_target;
      end
    end
  end

  assign o_branch_count     = r_branch_count;
  assign o_mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
// Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor #(.INDEX_BITS(4)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_if_pc            (if_pc),
    .o_pred_taken       (pred_taken),
    .o_pred_target      (pred_target),
    .i_res_valid        (res_valid),
    .i_res_pc           (res_pc),
    .i_res_taken        (res_taken),
    .i_res_target       (res_target),
    .i_res_pred_taken   (res_pred_taken),
    .i_res_pred_target  (res_pred_target),
    .o_mispredict       (mispredict),
    .o_redirect_pc      (redirect_pc),
    .o_branch_count     (branch_count),
    .o_mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    res_valid = 1'b1; res_pc = pc; res_taken = tk; res_target = tgt;
    res_pred_taken = ptk; res_pred_target = ptgt;
    #1;
  endtask

  task automatic idle();
    res_valid = 1'b0;
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick(); tick();
    rst = 1'b0;
    lookup(32'h40);
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred_taken got %0b exp 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL reset_pred_target got %h exp 00000044", pred_target); end
    n_cmp++; if (branch_count !== 32'd0) begin n_err++; $display("FAIL reset_branch_count got %0d exp 0", branch_count); end
    n_cmp++; if (mispredict_count !== 32'd0) begin n_err++; $display("FAIL reset_mispredict_count got %0d exp 0", mispredict_count); end
  endtask

  task automatic test_allocate();
    resolve(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL alloc_mispredict got %0b exp 1", mispredict); end
    n_cmp++; if (redirect_pc !== 32'h80) begin n_err++; $display("FAIL alloc_redirect got %h exp 00000080", redirect_pc); end
    tick(); idle();
    n_cmp++; if (mispredict_count !== 32'd1) begin n_err++; $display("FAIL alloc_mispredict_count got %0d exp 1", mispredict_count); end
    n_cmp++; if (branch_count !== 32'd1) begin n_err++; $display("FAIL alloc_branch_count got %0d exp 1", branch_count); end
    lookup(32'h40);
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alloc_lookup_taken got %0b exp 1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h80) begin n_err++; $display("FAIL alloc_lookup_target got %h exp 00000080", pred_target); end
    lookup(32'h43);
    n_cmp++; if (pred_target !== 32'h80) begin n_err++; $display("FAIL misaligned_lookup_target got %h exp 00000080", pred_target); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) begin
      resolve(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL sat_inc_mispredict[%0d] got %0b exp 0", i, mispredict); end
      tick();
    end
    resolve(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL nt1_mispredict got %0b exp 1", mispredict); end
    n_cmp++; if (redirect_pc !== 32'h44) begin n_err++; $display("FAIL nt1_redirect got %h exp 00000044", redirect_pc); end
    tick(); idle(); lookup(32'h40);
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL after_nt1_taken got %0b exp 1 (ctr 10)", pred_taken); end
    resolve(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    tick(); idle();
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL after_nt2_taken got %0b exp 0 (ctr 01)", pred_taken); end
    n_cmp++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL after_nt2_target got %h exp 00000044", pred_target); end
    n_cmp++; if (branch_count !== 32'd6) begin n_err++; $display("FAIL sat_branch_count got %0d exp 6", branch_count); end
    n_cmp++; if (mispredict_count !== 32'd3) begin n_err++; $display("FAIL sat_mispredict_count got %0d exp 3", mispredict_count); end
  endtask

  task automatic test_target_change();
    resolve(32'h40, 1'b1, 32'h80, 1'b0, 32'h44); tick();
    resolve(32'h40, 1'b1, 32'h80, 1'b1, 32'h80); tick();
    resolve(32'h40, 1'b1, 32'hC0, 1'b1, 32'h80);
    n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL tchg_mispredict got %0b exp 1", mispredict); end
    n_cmp++; if (redirect_pc !== 32'hC0) begin n_err++; $display("FAIL tchg_redirect got %h exp 000000c0", redirect_pc); end
    tick(); idle(); lookup(32'h40);
    n_cmp++; if (pred_target !== 32'hC0) begin n_err++; $display("FAIL tchg_lookup_target got %h exp 000000c0", pred_target); end
    n_cmp++; if (mispredict_count !== 32'd5) begin n_err++; $display("FAIL tchg_mispredict_count got %0d exp 5", mispredict_count); end
  endtask

  task automatic test_alias();
    resolve(32'h80, 1'b1, 32'h100, 1'b0, 32'h84); tick(); idle();
    lookup(32'h40);
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_evicted_taken got %0b exp 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL alias_evicted_target got %h exp 00000044", pred_target); end
    lookup(32'h80);
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alias_new_taken got %0b exp 1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h100) begin n_err++; $display("FAIL alias_new_target got %h exp 00000100", pred_target); end
  endtask

  task automatic test_collision();
    lookup(32'h80);
    resolve(32'h80, 1'b0, 32'h100, 1'b1, 32'h100);
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL coll_old_taken got %0b exp 1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h100) begin n_err++; $display("FAIL coll_old_target got %h exp 00000100", pred_target); end
    n_cmp++; if (redirect_pc !== 32'h84) begin n_err++; $display("FAIL coll_redirect got %h exp 00000084", redirect_pc); end
    tick(); idle();
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL coll_new_taken got %0b exp 0", pred_taken); end
    resolve(32'h44, 1'b0, 32'h200, 1'b0, 32'h48);
    n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL nt_miss_mispredict got %0b exp 0", mispredict); end
    tick(); idle(); lookup(32'h44);
    n_cmp++; if (pred_target !== 32'h48) begin n_err++; $display("FAIL nt_miss_lookup got %h exp 00000048", pred_target); end
    n_cmp++; if (branch_count !== 32'd12) begin n_err++; $display("FAIL coll_branch_count got %0d exp 12", branch_count); end
    n_cmp++; if (mispredict_count !== 32'd7) begin n_err++; $display("FAIL coll_mispredict_count got %0d exp 7", mispredict_count); end
  endtask

  task automatic test_reset_override();
    resolve(32'h80, 1'b1, 32'h100, 1'b0, 32'h84); tick(); idle();
    lookup(32'h80);
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL pre_rst_taken got %0b exp 1", pred_taken); end
    rst = 1'b1;
    resolve(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL in_rst_taken got %0b exp 0", pred_taken); end
    tick(); rst = 1'b0; idle();
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL post_rst_taken got %0b exp 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h84) begin n_err++; $display("FAIL post_rst_target got %h exp 00000084", pred_target); end
    n_cmp++; if (branch_count !== 32'd0) begin n_err++; $display("FAIL post_rst_branch_count got %0d exp 0", branch_count); end
    n_cmp++; if (mispredict_count !== 32'd0) begin n_err++; $display("FAIL post_rst_mispredict_count got %0d exp 0", mispredict_count); end
  endtask

  task automatic test_wrap();
    lookup(32'hFFFF_FFFC);
    n_cmp++; if (pred_target !== 32'h0) begin n_err++; $display("FAIL wrap_pred_target got %h exp 00000000", pred_target); end
    resolve(32'hFFFF_FFFC, 1'b0, 32'h1000, 1'b1, 32'h1000);
    n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL wrap_redirect got %h exp 00000000", redirect_pc); end
    tick(); idle();
    n_cmp++; if (branch_count !== 32'd1) begin n_err++; $display("FAIL wrap_branch_count got %0d exp 1", branch_count); end
    n_cmp++; if (mispredict_count !== 32'd1) begin n_err++; $display("FAIL wrap_mispredict_count got %0d exp 1", mispredict_count); end
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'h0; res_valid = 1'b0; res_pc = 32'h0; res_taken = 1'b0;
    res_target = 32'h0; res_pred_taken = 1'b0; res_pred_target = 32'h0;
    #1;
    test_reset();
    test_allocate();
    test_saturate();
    test_target_change();
    test_alias();
    test_collision();
    test_reset_override();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage branch predictor: a direct-mapped table of 2-bit saturating counters with targets (BHT plus BTB).
- Feeds the predicted next PC to fetch.
- Takes the resolved outcome from the ID-stage branch comparator (taken/not-taken, target) back into the table.
- Detects mispredictions and drives the redirect PC and flush to IF/ID.

Parameters:
- INDEX_BITS, 4, table index width; entries = 2^INDEX_BITS; index = pc[INDEX_BITS+1:2].
- TAG_BITS, 30-INDEX_BITS (derived, not overridable), tag = pc[31:INDEX_BITS+2].

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_if_pc  input  32  PC currently being fetched.
- o_pred_taken  output  1  prediction for i_if_pc: 1 = taken.
- o_pred_target  output  32  predicted next PC: stored target if o_pred_taken, else i_if_pc+4.
- i_res_valid  input  1  a branch resolves in ID this cycle.
- i_res_pc  input  32  PC of the resolving branch.
- i_res_taken  input  1  actual outcome from the branch comparator.
- i_res_target  input  32  computed branch target.
- i_res_pred_taken  input  1  prediction that was made for this branch, carried down the pipe.
- i_res_pred_target  input  32  predicted next PC that was carried down the pipe.
- o_mispredict  output  1  flush IF/ID and redirect this cycle.
- o_redirect_pc  output  32  correct next PC when o_mispredict = 1.
- o_branch_count  output  32  number of resolved branches.
- o_mispredict_count  output  32  number of mispredictions.

Behaviour:
- Entry contents: valid (1), tag (TAG_BITS), ctr (2), target (32).
- Reset, synchronous (i_rst = 1 at a rising edge):
  - all valid = 0, all ctr = 2'b01, all target = 0.
  - both counters = 0.
  - reset overrides any update in the same cycle.
- Lookup, combinational from registered table state:
  - hit = valid[idx] && tag[idx] == i_if_pc tag.
  - o_pred_taken = hit && ctr[idx][1].
  - o_pred_target = o_pred_taken ? target[idx] : i_if_pc+4 (32-bit, wraps).
  - During reset and in the cycle after it: o_pred_taken = 0.
- Mispredict, combinational, same cycle as i_res_valid, zero latency:
  - o_mispredict = i_res_valid && (i_res_taken != i_res_pred_taken || (i_res_taken && i_res_target != i_res_pred_target)).
  - o_redirect_pc = i_res_taken ? i_res_target : i_res_pc+4.
  - o_redirect_pc is don't-care when o_mispredict = 0; drive the same formula.
- Update, at the rising edge when i_res_valid && !i_rst, at resolve index r:
  - Hit, taken: ctr = sat_inc(ctr), max 2'b11; target = i_res_target.
  - Hit, not taken: ctr = sat_dec(ctr), min 2'b00; target unchanged.
  - Miss, taken: allocate, overwriting any entry: valid = 1, tag = res tag, ctr = 2'b10, target = i_res_target.
  - Miss, not taken: no change.
- Statistics:
  - o_branch_count += 1 on each i_res_valid.
  - o_mispredict_count += 1 when o_mispredict = 1.
  - Both wrap modulo 2^32.
- Same-index collision (lookup and update in one cycle):
  - Lookup returns the pre-update value; no bypass.
  - The new value is visible from the next cycle.
- Aliasing: different PCs with equal index but different tags replace each other on a taken allocate; lookup of the evicted PC misses and predicts not-taken.
- Stall and bubble handling is upstream; i_res_valid must already be qualified. The block has no stall input.
- Misaligned PCs: pc[1:0] ignored.

Test Plan:
- Reset, then i_if_pc = 0x00000040 -> o_pred_taken = 0, o_pred_target = 0x00000044; both counters 0.
- Resolve pc = 0x40, taken, target = 0x80, pred_taken = 0 -> o_mispredict = 1, o_redirect_pc = 0x80, mispredict_count = 1. Next cycle, lookup 0x40 -> taken, target 0x80 (ctr = 10).
- Three further taken resolves of 0x40 -> ctr saturates at 11. Then two not-taken resolves with pred_taken = 1 -> first gives o_mispredict = 1, o_redirect_pc = 0x44. After both, ctr = 01 and lookup predicts not-taken.
- Alias: allocate 0x40 (taken to 0x80), then resolve 0x80 taken to 0x100 (same index when INDEX_BITS = 4) -> lookup 0x40 misses and returns 0x44; lookup 0x80 returns 0x100.
- Target change: entry 0x40 has ctr = 11, target 0x80; resolve taken to 0xC0 with pred_target 0x80 -> o_mispredict = 1, o_redirect_pc = 0xC0; stored target becomes 0xC0.
- Collision and reset: update and lookup on the same index in one cycle -> lookup shows the old value. i_rst = 1 together with i_res_valid -> table stays at its reset state and counters = 0.
